// File: rtl/ucie_sb_msg_pkg.sv
// Sideband message codes, lane-map encodings and REPAIR state encoding shared
// by the repair transmitter and responder.
package ucie_sb_msg_pkg;

    localparam logic [3:0] MSG_INIT_REQ     = 4'b0001;
    localparam logic [3:0] MSG_INIT_RESP    = 4'b0010;
    localparam logic [3:0] MSG_END_REQ      = 4'b0101;
    localparam logic [3:0] MSG_END_RESP     = 4'b0110;
    localparam logic [3:0] MSG_DEGRADE_REQ  = 4'b0111;
    localparam logic [3:0] MSG_DEGRADE_RESP = 4'b1000;

    localparam logic [2:0] LANES_ALL = 3'b011;
    localparam logic [2:0] LANES_LO  = 3'b001;
    localparam logic [2:0] LANES_HI  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WAIT_DEGRADE,
        ST_WAIT_END,
        ST_END_PEND,
        ST_TEST_FINISH,
        ST_ERROR
    } repair_state_e;

    function automatic logic is_legal_map(input logic [2:0] enc);
        return (enc == LANES_ALL) || (enc == LANES_LO) || (enc == LANES_HI);
    endfunction

endpackage

// File: rtl/repair_rx_if.sv
// Sideband request/response signals between the sideband block and the
// REPAIR responder.
interface repair_rx_if;

    logic [3:0] i_sideband_message;
    logic       i_sideband_valid;
    logic [2:0] i_sideband_data_lanes_encoding;
    logic       i_busy_negedge_detected;
    logic       i_valid_tx;
    logic [3:0] o_sideband_message;
    logic       o_valid_rx;

    modport slave (
        input  i_sideband_message,
        input  i_sideband_valid,
        input  i_sideband_data_lanes_encoding,
        input  i_busy_negedge_detected,
        input  i_valid_tx,
        output o_sideband_message,
        output o_valid_rx
    );

    modport master (
        output i_sideband_message,
        output i_sideband_valid,
        output i_sideband_data_lanes_encoding,
        output i_busy_negedge_detected,
        output i_valid_tx,
        input  o_sideband_message,
        input  o_valid_rx
    );

endinterface

// File: rtl/ltsm_timeout_counter.sv
// Wait-state watchdog shared by LTSM substates: counts enabled cycles and
// flags the last allowed cycle before the substate must give up.
module ltsm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = en && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/repair_rx.sv
// MBTRAIN.REPAIR partner-side responder: answers the remote transmitter's
// init, apply-degrade and end requests and latches the negotiated lane map.
module repair_rx #(
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    repair_rx_if.slave  sb,
    output logic [2:0]  o_lanes_map,
    output logic        o_test_ack,
    output logic        o_error
);

    import ucie_sb_msg_pkg::*;

    repair_state_e state, state_n;
    logic [3:0]    msg_q, msg_n;
    logic          valid_q, valid_n;
    logic          ack_q, ack_n;
    logic          err_q, err_n;
    logic [2:0]    map_q, map_n;

    logic rx_ok;
    logic valid_clear;
    logic waiting;
    logic expired;
    logic cnt_clr;

    // A new request is only considered while no response is outstanding.
    assign rx_ok       = sb.i_sideband_valid && !valid_q;
    assign valid_clear = valid_q && sb.i_busy_negedge_detected && !sb.i_valid_tx;
    assign waiting     = (state == ST_WAIT_INIT) || (state == ST_WAIT_DEGRADE) ||
                         (state == ST_WAIT_END)  || (state == ST_END_PEND);
    assign cnt_clr     = !i_en || (state_n != state);

    ltsm_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (waiting),
        .expired(expired)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        msg_n   = msg_q;
        valid_n = valid_q;
        ack_n   = ack_q;
        err_n   = err_q;
        map_n   = map_q;

        if (valid_clear) valid_n = 1'b0;

        if (!i_en) begin
            state_n = ST_IDLE;
            msg_n   = '0;
            valid_n = 1'b0;
            ack_n   = 1'b0;
            err_n   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    msg_n   = '0;
                    valid_n = 1'b0;
                    ack_n   = 1'b0;
                    err_n   = 1'b0;
                    state_n = ST_WAIT_INIT;
                end
                ST_WAIT_INIT: begin
                    if (rx_ok && sb.i_sideband_message == MSG_INIT_REQ) begin
                        msg_n   = MSG_INIT_RESP;
                        valid_n = 1'b1;
                        state_n = ST_WAIT_DEGRADE;
                    end else if (expired) begin
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                        state_n = ST_ERROR;
                    end
                end
                ST_WAIT_DEGRADE: begin
                    if (rx_ok && sb.i_sideband_message == MSG_DEGRADE_REQ) begin
                        if (is_legal_map(sb.i_sideband_data_lanes_encoding)) begin
                            map_n   = sb.i_sideband_data_lanes_encoding;
                            msg_n   = MSG_DEGRADE_RESP;
                            valid_n = 1'b1;
                            state_n = ST_WAIT_END;
                        end else begin
                            err_n   = 1'b1;
                            state_n = ST_ERROR;
                        end
                    end else if (expired) begin
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                        state_n = ST_ERROR;
                    end
                end
                ST_WAIT_END: begin
                    if (rx_ok && sb.i_sideband_message == MSG_END_REQ) begin
                        msg_n   = MSG_END_RESP;
                        valid_n = 1'b1;
                        state_n = ST_END_PEND;
                    end else if (expired) begin
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                        state_n = ST_ERROR;
                    end
                end
                ST_END_PEND: begin
                    // Done only once the END_RESP has actually left the sideband.
                    if (valid_clear) begin
                        ack_n   = 1'b1;
                        state_n = ST_TEST_FINISH;
                    end else if (expired) begin
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                        state_n = ST_ERROR;
                    end
                end
                ST_TEST_FINISH: ack_n = 1'b1;
                ST_ERROR: begin
                    valid_n = 1'b0;
                    err_n   = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            msg_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            map_q   <= '0;
        end else begin
            state   <= state_n;
            msg_q   <= msg_n;
            valid_q <= valid_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
            map_q   <= map_n;
        end
    end

    assign sb.o_sideband_message = msg_q;
    assign sb.o_valid_rx         = valid_q;
    assign o_lanes_map           = map_q;
    assign o_test_ack            = ack_q;
    assign o_error               = err_q;

endmodule

// File: tb/tb_repair_rx.sv
// Scoreboard bench for repair_rx: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT raises its outputs.
module tb_repair_rx;

    import ucie_sb_msg_pkg::*;

    localparam int TO = 64;

    typedef enum logic [1:0] {EV_RESP, EV_ACK, EV_ERR} ev_e;
    typedef struct {
        ev_e        kind;
        logic [3:0] msg;
        logic [2:0] map;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic i_en;
    logic [2:0] o_lanes_map;
    logic o_test_ack;
    logic o_error;

    repair_rx_if sb_if ();

    repair_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .sb         (sb_if),
        .o_lanes_map(o_lanes_map),
        .o_test_ack (o_test_ack),
        .o_error    (o_error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [2:0] exp_map = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input ev_e kind, input logic [3:0] msg);
        exp_t e;
        e.kind = kind;
        e.msg  = msg;
        e.map  = exp_map;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] code, input logic [2:0] enc);
        sb_if.i_sideband_valid = 1'b1;
        sb_if.i_sideband_message = code;
        sb_if.i_sideband_data_lanes_encoding = enc;
        tick();
        sb_if.i_sideband_valid = 1'b0;
        sb_if.i_sideband_message = 4'b0000;
        sb_if.i_sideband_data_lanes_encoding = 3'b000;
    endtask

    task automatic busy_negedge(input logic tx);
        sb_if.i_busy_negedge_detected = 1'b1;
        sb_if.i_valid_tx = tx;
        tick();
        sb_if.i_busy_negedge_detected = 1'b0;
        sb_if.i_valid_tx = 1'b0;
    endtask

    task automatic handle(input ev_e kind, input logic [3:0] msg);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d msg %0h expected none at %0t", kind, msg, $time);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_RESP) check("ev_msg", 32'(msg), 32'(e.msg));
            check("ev_map", 32'(o_lanes_map), 32'(e.map));
        end
    endtask

    // Monitor: outputs sampled on the falling edge, events on rising outputs.
    initial begin
        logic pv, pa, pe;
        pv = 1'b0; pa = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (sb_if.o_valid_rx && !pv) handle(EV_RESP, sb_if.o_sideband_message);
                if (o_test_ack && !pa) handle(EV_ACK, 4'b0000);
                if (o_error && !pe) handle(EV_ERR, 4'b0000);
            end
            pv = sb_if.o_valid_rx;
            pa = o_test_ack;
            pe = o_error;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        i_en = 1'b0;
        sb_if.i_sideband_valid = 1'b0;
        sb_if.i_sideband_message = 4'b0000;
        sb_if.i_sideband_data_lanes_encoding = 3'b000;
        sb_if.i_busy_negedge_detected = 1'b0;
        sb_if.i_valid_tx = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(sb_if.o_valid_rx), 0);
        check("rst_msg", 32'(sb_if.o_sideband_message), 0);
        check("rst_map", 32'(o_lanes_map), 0);
        check("rst_ack_err", 32'({o_test_ack, o_error}), 0);
        rst_n = 1'b1;
        tick();

        // Nominal run, full map.
        i_en = 1'b1; tick();
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        check("init_resp_valid", 32'(sb_if.o_valid_rx), 1);
        check("init_resp_msg", 32'(sb_if.o_sideband_message), 32'(MSG_INIT_RESP));
        busy_negedge(1'b0);
        check("init_clear", 32'(sb_if.o_valid_rx), 0);
        exp_map = LANES_ALL;
        expect_ev(EV_RESP, MSG_DEGRADE_RESP);
        send(MSG_DEGRADE_REQ, 3'b011);
        check("map_all", 32'(o_lanes_map), 32'(3'b011));
        busy_negedge(1'b0);
        expect_ev(EV_RESP, MSG_END_RESP);
        send(MSG_END_REQ, 3'b000);
        check("end_no_ack_yet", 32'(o_test_ack), 0);
        expect_ev(EV_ACK, 4'b0000);
        busy_negedge(1'b0);
        check("ack_set", 32'(o_test_ack), 1);
        check("ack_valid_clr", 32'(sb_if.o_valid_rx), 0);
        i_en = 1'b0; tick();
        check("ack_drop", 32'(o_test_ack), 0);
        check("map_kept", 32'(o_lanes_map), 32'(3'b011));

        // Lower-half map with sideband contention.
        i_en = 1'b1; tick();
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        busy_negedge(1'b0);
        exp_map = LANES_LO;
        expect_ev(EV_RESP, MSG_DEGRADE_RESP);
        send(MSG_DEGRADE_REQ, 3'b001);
        check("map_lo", 32'(o_lanes_map), 32'(3'b001));
        send(MSG_END_REQ, 3'b000);
        check("end_while_busy_msg", 32'(sb_if.o_sideband_message), 32'(MSG_DEGRADE_RESP));
        busy_negedge(1'b1);
        check("contention_hold", 32'(sb_if.o_valid_rx), 1);
        busy_negedge(1'b0);
        check("contention_clear", 32'(sb_if.o_valid_rx), 0);
        expect_ev(EV_RESP, MSG_END_RESP);
        send(MSG_END_REQ, 3'b000);
        expect_ev(EV_ACK, 4'b0000);
        busy_negedge(1'b0);
        check("ack_lo", 32'(o_test_ack), 1);
        i_en = 1'b0; tick();

        // Ordering: early END_REQ and an INIT_REQ without valid are ignored.
        i_en = 1'b1; tick();
        send(MSG_END_REQ, 3'b000);
        check("early_end_ignored", 32'(sb_if.o_valid_rx), 0);
        sb_if.i_sideband_message = MSG_INIT_REQ;
        tick();
        sb_if.i_sideband_message = 4'b0000;
        check("novalid_ignored", 32'(sb_if.o_valid_rx), 0);
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        busy_negedge(1'b0);
        exp_map = LANES_HI;
        expect_ev(EV_RESP, MSG_DEGRADE_RESP);
        send(MSG_DEGRADE_REQ, 3'b010);
        check("map_hi", 32'(o_lanes_map), 32'(3'b010));
        busy_negedge(1'b0);
        expect_ev(EV_RESP, MSG_END_RESP);
        send(MSG_END_REQ, 3'b000);
        expect_ev(EV_ACK, 4'b0000);
        busy_negedge(1'b0);
        i_en = 1'b0; tick();

        // Illegal maps 000 and 101: error, no response, map unchanged.
        for (int k = 0; k < 2; k++) begin
            i_en = 1'b1; tick();
            expect_ev(EV_RESP, MSG_INIT_RESP);
            send(MSG_INIT_REQ, 3'b000);
            busy_negedge(1'b0);
            expect_ev(EV_ERR, 4'b0000);
            send(MSG_DEGRADE_REQ, (k == 0) ? 3'b000 : 3'b101);
            check("illegal_err", 32'(o_error), 1);
            check("illegal_no_resp", 32'(sb_if.o_valid_rx), 0);
            check("illegal_map_kept", 32'(o_lanes_map), 32'(3'b010));
            i_en = 1'b0; tick();
            check("illegal_err_clr", 32'(o_error), 0);
        end

        // Timeout in WAIT_DEGRADE: error exactly TO cycles after entry.
        i_en = 1'b1; tick();
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        busy_negedge(1'b0);
        expect_ev(EV_ERR, 4'b0000);
        n = 1;
        while (!o_error && n < 3 * TO) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO));
        check("timeout_valid", 32'(sb_if.o_valid_rx), 0);
        i_en = 1'b0; tick();

        // Abort while a response is outstanding, then a clean restart.
        i_en = 1'b1; tick();
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        check("pre_abort_valid", 32'(sb_if.o_valid_rx), 1);
        i_en = 1'b0; tick();
        check("abort_valid", 32'(sb_if.o_valid_rx), 0);
        check("abort_msg", 32'(sb_if.o_sideband_message), 0);
        check("abort_ack_err", 32'({o_test_ack, o_error}), 0);
        i_en = 1'b1; tick();
        expect_ev(EV_RESP, MSG_INIT_RESP);
        send(MSG_INIT_REQ, 3'b000);
        check("restart_msg", 32'(sb_if.o_sideband_message), 32'(MSG_INIT_RESP));
        i_en = 1'b0;
        repeat (3) tick();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
